// File: rtl/instr_encoder.sv
// Packs field-level WISC instruction requests into 16-bit words, range-checks
// immediates, queues accepted words and streams them to imem at consecutive addresses.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [2:0]  in_rs,
    input  logic [2:0]  in_rt,
    input  logic [2:0]  in_rd,
    input  logic [1:0]  in_op_ext,
    input  logic [15:0] in_imm,
    output logic        mem_wr_en,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        err,
    output logic [7:0]  err_count,
    output logic        done
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned WORD_W = 16;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_ROLL  = 5'b11010;
    localparam logic [4:0] OP_ARITH = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0]   fifo_q [DEPTH];
    logic [WORD_W-1:0]   fifo_d [DEPTH];
    logic [15:0]         mem_addr_q, mem_addr_d;
    logic                halt_seen_q, halt_seen_d;
    logic                err_q, err_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                done_q, done_d;

    logic                full_c, empty_c, fire_c, push_c, pop_c;
    logic                legal_c;
    logic [WORD_W-1:0]   word_c;
    logic                simm5_ok_c, zimm5_ok_c, simm8_ok_c, zimm8_ok_c, disp11_ok_c;

    // A signed range fits when all bits above the field's sign bit equal it.
    assign simm5_ok_c  = (&in_imm[15:4])  | ~(|in_imm[15:4]);
    assign zimm5_ok_c  = ~(|in_imm[15:5]);
    assign simm8_ok_c  = (&in_imm[15:7])  | ~(|in_imm[15:7]);
    assign zimm8_ok_c  = ~(|in_imm[15:8]);
    assign disp11_ok_c = (&in_imm[15:10]) | ~(|in_imm[15:10]);

    // Field packing per instruction format.
    always_comb begin
        word_c  = {in_opcode, 11'b0};
        legal_c = 1'b0;
        case (in_opcode)
            OP_HALT, OP_NOP: begin
                legal_c = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: begin
                word_c  = {in_opcode, in_rs, in_rd, in_imm[4:0]};
                legal_c = simm5_ok_c;
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                word_c  = {in_opcode, in_rs, in_rd, in_imm[4:0]};
                legal_c = zimm5_ok_c;
            end
            OP_ARITH, OP_ROLL: begin
                word_c  = {in_opcode, in_rs, in_rt, in_rd, in_op_ext};
                legal_c = 1'b1;
            end
            OP_BTR, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                word_c  = {in_opcode, in_rs, in_rt, in_rd, 2'b00};
                legal_c = 1'b1;
            end
            OP_LBI, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ, OP_JR, OP_JALR: begin
                word_c  = {in_opcode, in_rs, in_imm[7:0]};
                legal_c = simm8_ok_c;
            end
            OP_SLBI: begin
                word_c  = {in_opcode, in_rs, in_imm[7:0]};
                legal_c = zimm8_ok_c;
            end
            OP_J, OP_JAL: begin
                word_c  = {in_opcode, in_imm[10:0]};
                legal_c = disp11_ok_c;
            end
            default: begin
                word_c  = {in_opcode, 11'b0};
                legal_c = 1'b0;
            end
        endcase
    end

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fire_c  = in_valid & in_ready;
    assign push_c  = fire_c & legal_c;
    assign pop_c   = ~empty_c & mem_ready;

    // Next-state for queue, address, status flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_d       = fifo_q;
        mem_addr_d   = mem_addr_q;
        halt_seen_d  = halt_seen_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        done_d       = done_q;

        if (push_c) begin
            fifo_d[wr_ptr_q[PTR_W-1:0]] = word_c;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (in_opcode == OP_HALT) begin
                halt_seen_d = 1'b1;
            end
        end
        if (fire_c && !legal_c) begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
        if (pop_c) begin
            rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(1);
            mem_addr_d = mem_addr_q + 16'd2;
            if (mem_wdata[15:11] == OP_HALT) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= BASE_ADDR;
            halt_seen_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_addr_q  <= mem_addr_d;
            halt_seen_q <= halt_seen_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign in_ready  = ~full_c & ~halt_seen_q;
    assign mem_wr_en = ~empty_c;
    assign mem_wdata = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign mem_addr  = mem_addr_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: one instance at BASE_ADDR 0, one at 16'hFFFE.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  in_opcode;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic [1:0]  in_op_ext;
    logic [15:0] in_imm;

    logic        in_valid0, in_ready0, mem_wr_en0, mem_ready0, err0, done0;
    logic [15:0] mem_addr0, mem_wdata0;
    logic [7:0]  err_count0;
    logic        in_valid1, in_ready1, mem_wr_en1, mem_ready1, err1, done1;
    logic [15:0] mem_addr1, mem_wdata1;
    logic [7:0]  err_count1;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_addr [2];

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(4), .BASE_ADDR(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_op_ext(in_op_ext), .in_imm(in_imm),
        .mem_wr_en(mem_wr_en0), .mem_ready(mem_ready0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .err(err0), .err_count(err_count0), .done(done0)
    );

    instr_encoder #(.DEPTH(4), .BASE_ADDR(16'hFFFE)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_op_ext(in_op_ext), .in_imm(in_imm),
        .mem_wr_en(mem_wr_en1), .mem_ready(mem_ready1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .err(err1), .err_count(err_count1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [4:0] op, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [2:0] rd,
                        input logic [1:0] ext, input logic [15:0] imm);
        in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd; in_op_ext = ext; in_imm = imm;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    // Head word must be presented at the tracked address, then pop with mem_ready=1.
    task automatic expect_word(input bit sel, input logic [15:0] w, input string tag);
        chk({tag, "_wr_en"}, 16'(sel ? mem_wr_en1 : mem_wr_en0), 16'd1);
        chk({tag, "_wdata"}, sel ? mem_wdata1 : mem_wdata0, w);
        chk({tag, "_addr"},  sel ? mem_addr1  : mem_addr0,  exp_addr[sel]);
        tick();
        exp_addr[sel] = exp_addr[sel] + 16'd2;
        chk({tag, "_addr_next"}, sel ? mem_addr1 : mem_addr0, exp_addr[sel]);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        mem_ready0 = 1'b1; mem_ready1 = 1'b1;
        in_opcode = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_op_ext = '0; in_imm = '0;
        exp_addr[0] = 16'h0000;
        exp_addr[1] = 16'hFFFE;
        tick(); tick();

        chk("rst_wr_en",  16'(mem_wr_en0), 16'd0);
        chk("rst_addr",   mem_addr0, 16'h0000);
        chk("rst_err",    16'(err0), 16'd0);
        chk("rst_errcnt", 16'(err_count0), 16'd0);
        chk("rst_done",   16'(done0), 16'd0);
        chk("rst_addr1",  mem_addr1, 16'hFFFE);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 16'(in_ready0), 16'd1);

        // Basic encodings across formats
        send(0, 5'b01000, 3'd2, 3'd0, 3'd1, 2'b00, 16'hFFFD);      // ADDI -3
        expect_word(0, 16'h423D, "addi");
        send(0, 5'b11011, 3'd1, 3'd2, 3'd3, 2'b00, 16'h0000);      // ARITH
        chk("arith_wdata", mem_wdata0, 16'hD94C);
        send(0, 5'b11000, 3'd4, 3'd0, 3'd0, 2'b00, 16'hFFFF);      // LBI -1, pops ARITH
        exp_addr[0] = exp_addr[0] + 16'd2;
        expect_word(0, 16'hC4FF, "lbi");
        send(0, 5'b00100, 3'd0, 3'd0, 3'd0, 2'b00, 16'hFFFE);      // J -2
        expect_word(0, 16'h27FE, "j_neg2");
        send(0, 5'b11100, 3'd1, 3'd2, 3'd3, 2'b11, 16'h0000);      // SEQ ext forced 00
        expect_word(0, 16'hE14C, "seq_ext");
        send(0, 5'b01000, 3'd0, 3'd0, 3'd0, 2'b00, 16'd15);        // ADDI max
        expect_word(0, 16'h400F, "addi_15");
        send(0, 5'b01010, 3'd0, 3'd0, 3'd0, 2'b00, 16'd31);        // XORI max
        expect_word(0, 16'h501F, "xori_31");

        // Rejections
        send(0, 5'b00100, 3'd0, 3'd0, 3'd0, 2'b00, 16'd1024);      // J out of range
        chk("jrej_err",    16'(err0), 16'd1);
        chk("jrej_cnt",    16'(err_count0), 16'd1);
        chk("jrej_wr_en",  16'(mem_wr_en0), 16'd0);
        tick();
        chk("jrej_err_pulse", 16'(err0), 16'd0);
        chk("jrej_addr",   mem_addr0, exp_addr[0]);
        send(0, 5'b00010, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);         // undefined opcode
        chk("undef_err",   16'(err0), 16'd1);
        chk("undef_cnt",   16'(err_count0), 16'd2);
        send(0, 5'b01000, 3'd0, 3'd0, 3'd0, 2'b00, 16'd16);        // ADDI just out of range
        chk("addi16_cnt",  16'(err_count0), 16'd3);
        chk("addi16_wr_en", 16'(mem_wr_en0), 16'd0);
        tick();

        // Fill the FIFO while imem stalls
        mem_ready0 = 1'b0;
        send(0, 5'b00001, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);         // NOP
        chk("stall_head", mem_wdata0, 16'h0800);
        send(0, 5'b10010, 3'd3, 3'd0, 3'd0, 2'b00, 16'd255);       // SLBI 255
        send(0, 5'b01100, 3'd5, 3'd0, 3'd0, 2'b00, 16'hFF80);      // BEQZ -128
        chk("stall_ready3", 16'(in_ready0), 16'd1);
        send(0, 5'b00110, 3'd0, 3'd0, 3'd0, 2'b00, 16'd1023);      // JAL 1023
        chk("full_ready",  16'(in_ready0), 16'd0);
        chk("stall_addr",  mem_addr0, exp_addr[0]);
        mem_ready0 = 1'b1;
        chk("full_pop_ready", 16'(in_ready0), 16'd0);
        expect_word(0, 16'h0800, "drain0");
        expect_word(0, 16'h93FF, "drain1");
        expect_word(0, 16'h6580, "drain2");
        expect_word(0, 16'h33FF, "drain3");
        chk("drain_empty", 16'(mem_wr_en0), 16'd0);

        // Reset with words queued
        mem_ready0 = 1'b0;
        send(0, 5'b00001, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);
        send(0, 5'b00001, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);
        send(0, 5'b00001, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);
        chk("q3_wr_en", 16'(mem_wr_en0), 16'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_wr_en",  16'(mem_wr_en0), 16'd0);
        chk("mid_rst_addr",   mem_addr0, 16'h0000);
        chk("mid_rst_done",   16'(done0), 16'd0);
        chk("mid_rst_errcnt", 16'(err_count0), 16'd0);
        rst_n = 1'b1;
        mem_ready0 = 1'b1;
        tick();
        chk("post_rst_wr_en", 16'(mem_wr_en0), 16'd0);
        exp_addr[0] = 16'h0000;
        exp_addr[1] = 16'hFFFE;
        send(0, 5'b01000, 3'd2, 3'd0, 3'd1, 2'b00, 16'hFFFD);
        expect_word(0, 16'h423D, "post_rst_addi");

        // Address wrap and HALT on the high-base instance
        send(1, 5'b01000, 3'd2, 3'd0, 3'd1, 2'b00, 16'hFFFD);
        expect_word(1, 16'h423D, "wrap0");
        chk("wrap_addr", mem_addr1, 16'h0000);
        send(1, 5'b00001, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);
        expect_word(1, 16'h0800, "wrap1");
        send(1, 5'b00000, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);         // HALT
        chk("halt_ready", 16'(in_ready1), 16'd0);
        chk("halt_done_early", 16'(done1), 16'd0);
        expect_word(1, 16'h0000, "halt_word");
        chk("halt_done", 16'(done1), 16'd1);
        send(1, 5'b00001, 3'd0, 3'd0, 3'd0, 2'b00, 16'd0);         // ignored
        chk("halt_sticky",  16'(done1), 16'd1);
        chk("halt_ready2",  16'(in_ready1), 16'd0);
        chk("halt_no_write", 16'(mem_wr_en1), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
